// File: rtl/serial_pair_adder_if.sv
// serial_pair_adder_if: operand and result handshakes of the serial pair adder
interface serial_pair_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_pair_adder.sv
// serial_pair_adder: WIDTH-bit adder built from one 2-bit slice stepped LSB pair first
module serial_pair_adder #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    serial_pair_adder_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam int KW = (HALF > 1) ? $clog2(HALF) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic             cout_r;
    logic             ovf_r;
    logic [2:0]       slice;
    logic             last;
    assign slice = 3'(a_sh[1:0]) + 3'(b_sh[1:0]) + 3'(carry);
    assign last = (k == KW'(HALF - 1));
    assign bus.in_ready = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf = ovf_r;
    // accept operands, step the slice once per RUN cycle, hold the result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_sh  <= bus.a;
                    b_sh  <= bus.b;
                    a_msb <= bus.a[WIDTH-1];
                    b_msb <= bus.b[WIDTH-1];
                    carry <= bus.cin;
                    k     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum_r <= WIDTH'({slice[1:0], sum_r} >> 2);
                    a_sh  <= a_sh >> 2;
                    b_sh  <= b_sh >> 2;
                    carry <= slice[2];
                    k     <= last ? k : k + KW'(1);
                    if (last) begin
                        cout_r <= slice[2];
                        ovf_r  <= slice[1] ^ a_msb ^ b_msb ^ slice[2];
                        state  <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pair_adder.sv
// tb_serial_pair_adder: directed vectors checked through an expected-result scoreboard
module tb_serial_pair_adder;
    localparam int WIDTH = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    always #5 clk = ~clk;
    serial_pair_adder_if #(.WIDTH(WIDTH)) bus ();
    serial_pair_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask
    // monitor: every accepted result is compared against the oldest expectation
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_result: got sum %0h with no expectation queued", bus.sum);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 32'(bus.sum), 32'(e[9:2]));
                chk("cout", 32'(bus.cout), 32'(e[1]));
                chk("ovf", 32'(bus.ovf), 32'(e[0]));
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic push, input logic [9:0] e);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        if (push) exp_q.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.cin = 1'($urandom);
    endtask
    task automatic wait_out();
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        send(8'h35, 8'h4A, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b0});
        repeat (3) tick();
        chk("lat_out_valid_early", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        send(8'hFF, 8'h00, 1'b1, 1'b1, {8'h00, 1'b1, 1'b0});
        send(8'h7F, 8'h01, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
        send(8'h80, 8'h80, 1'b0, 1'b1, {8'h00, 1'b1, 1'b1});
        drain();
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1'b1, {8'h46, 1'b0, 1'b0});
        wait_out();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'(i % 2);
            bus.a = 8'hFF;
            bus.b = 8'h77;
            bus.cin = 1'b1;
            tick();
            chk("stall_sum", 32'(bus.sum), 32'h46);
            chk("stall_cout", 32'(bus.cout), 32'd0);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        tick();
        chk("after_stall_out_valid", 32'(bus.out_valid), 32'd0);
        send(8'hAA, 8'h55, 1'b0, 1'b0, 10'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrun_rst_sum", 32'(bus.sum), 32'd0);
        chk("midrun_rst_cout", 32'(bus.cout), 32'd0);
        send(8'h01, 8'h01, 1'b0, 1'b1, {8'h02, 1'b0, 1'b0});
        drain();
        fork
            begin
                send(8'hC8, 8'h9C, 1'b1, 1'b1, {8'h65, 1'b1, 1'b1});
                send(8'hF0, 8'h10, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0});
                send(8'h55, 8'h2A, 1'b1, 1'b1, {8'h80, 1'b0, 1'b1});
                send(8'h00, 8'h00, 1'b0, 1'b1, {8'h00, 1'b0, 1'b0});
                send(8'hFF, 8'hFF, 1'b1, 1'b1, {8'hFF, 1'b1, 1'b0});
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        repeat (3) tick();
        chk("final_out_valid", 32'(bus.out_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
